// File: rtl/hevc_interp_pkg.sv
// Shared constants for the HEVC luma interpolation pipe: phase/mode codes,
// the 8-tap coefficient table and the accumulator width rule.
package hevc_interp_pkg;

  localparam logic [1:0] PH_FULL = 2'd0;
  localparam logic [1:0] PH_Q    = 2'd1;
  localparam logic [1:0] PH_H    = 2'd2;
  localparam logic [1:0] PH_3Q   = 2'd3;

  localparam logic MODE_FINAL = 1'b0;
  localparam logic MODE_INT   = 1'b1;

  // 8 bits wide so the full-pel centre tap of +64 is representable as signed.
  localparam int COEF_W = 8;
  typedef logic signed [COEF_W-1:0] coef_t;

  localparam coef_t COEF_TBL [4][8] = '{
    '{ 8'sd0,  8'sd0,  8'sd0,   8'sd64, 8'sd0,  8'sd0,   8'sd0,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd10,  8'sd58, 8'sd17, -8'sd5,  8'sd1,  8'sd0 },
    '{-8'sd1,  8'sd4, -8'sd11,  8'sd40, 8'sd40, -8'sd11, 8'sd4, -8'sd1 },
    '{ 8'sd0,  8'sd1, -8'sd5,   8'sd17, 8'sd58, -8'sd10, 8'sd4, -8'sd1 }
  };

  function automatic int sum_w(input int bit_depth);
    return bit_depth + 8;
  endfunction

endpackage

// File: rtl/hevc_round_clip.sv
// Stage-3 post-processing: round+clip to a pixel (final) or shift+saturate
// to a signed intermediate for the second pass of a separable filter.
module hevc_round_clip
  import hevc_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int INT_W     = 16,
  parameter int SUM_W     = BIT_DEPTH + 8
) (
  input  logic signed [SUM_W-1:0] sum_i,
  input  logic                    mode_i,
  output logic [INT_W-1:0]        res_o
);

  localparam int EXT_W = SUM_W + INT_W;
  localparam logic signed [SUM_W:0]   PIX_MAX = (SUM_W+1)'((1 << BIT_DEPTH) - 1);
  localparam logic signed [EXT_W-1:0] INT_MAX = EXT_W'((64'sd1 <<< (INT_W-1)) - 64'sd1);
  localparam logic signed [EXT_W-1:0] INT_MIN = -INT_MAX - EXT_W'(1);

  logic signed [SUM_W:0]   rnd;
  logic signed [SUM_W-1:0] shr;
  logic signed [EXT_W-1:0] shr_x;
  logic [BIT_DEPTH-1:0]    pix;
  logic [INT_W-1:0]        sat;

  always_comb begin
    // One guard bit keeps the +32 rounding offset from wrapping.
    rnd = ((SUM_W+1)'(sum_i) + (SUM_W+1)'(32)) >>> 6;
    if (rnd[SUM_W])          pix = '0;
    else if (rnd > PIX_MAX)  pix = '1;
    else                     pix = rnd[BIT_DEPTH-1:0];

    shr   = sum_i >>> (BIT_DEPTH - 8);
    shr_x = EXT_W'(shr);
    if (shr_x > INT_MAX)      sat = INT_MAX[INT_W-1:0];
    else if (shr_x < INT_MIN) sat = INT_MIN[INT_W-1:0];
    else                      sat = shr_x[INT_W-1:0];

    res_o = (mode_i == MODE_INT) ? sat : INT_W'(pix);
  end

endmodule

// File: rtl/hevc_luma_interp_pipe.sv
// 8-tap HEVC luma sub-pel filter, 3-stage pipe (products / sum / round-clip)
// with a single global stall enable derived from output backpressure.
module hevc_luma_interp_pipe
  import hevc_interp_pkg::*;
#(
  parameter int BIT_DEPTH = 8,
  parameter int SB_W      = 2,
  parameter int INT_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*BIT_DEPTH-1:0] in_pixels,
  input  logic [1:0]             in_phase,
  input  logic                   in_mode,
  input  logic [SB_W-1:0]        in_sb,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INT_W-1:0]       out_pixel,
  output logic [SB_W-1:0]        out_sb
);

  localparam int SUM_W  = sum_w(BIT_DEPTH);
  localparam int STAGES = 3;

  logic                    en;
  logic [STAGES:1]         vld_q;
  logic [7:0][SUM_W-1:0]   prod_d, prod_q;
  logic signed [SUM_W-1:0] sum_d, sum_q;
  logic [INT_W-1:0]        pix_d, pix_q;
  logic                    mode1_q, mode2_q;
  logic [SB_W-1:0]         sb1_q, sb2_q, sb3_q;

  assign en        = !(vld_q[STAGES] && !out_ready);
  assign in_ready  = en;
  assign out_valid = vld_q[STAGES];
  assign out_pixel = pix_q;
  assign out_sb    = sb3_q;

  // Taps are unsigned: zero-extend before the signed multiply.
  for (genvar k = 0; k < 8; k++) begin : g_tap
    logic signed [SUM_W-1:0] px_s, cf_s;
    assign px_s      = SUM_W'(in_pixels[k*BIT_DEPTH +: BIT_DEPTH]);
    assign cf_s      = SUM_W'(COEF_TBL[in_phase][k]);
    assign prod_d[k] = cf_s * px_s;
  end

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < 8; k++) sum_d = sum_d + $signed(prod_q[k]);
  end

  hevc_round_clip #(
    .BIT_DEPTH (BIT_DEPTH),
    .INT_W     (INT_W),
    .SUM_W     (SUM_W)
  ) u_round_clip (
    .sum_i  (sum_q),
    .mode_i (mode2_q),
    .res_o  (pix_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q   <= '0;
      prod_q  <= '0;
      sum_q   <= '0;
      pix_q   <= '0;
      mode1_q <= MODE_FINAL;
      mode2_q <= MODE_FINAL;
      sb1_q   <= '0;
      sb2_q   <= '0;
      sb3_q   <= '0;
    end else if (en) begin
      vld_q   <= {vld_q[STAGES-1:1], in_valid};
      prod_q  <= prod_d;
      mode1_q <= in_mode;
      sb1_q   <= in_sb;
      sum_q   <= sum_d;
      mode2_q <= mode1_q;
      sb2_q   <= sb1_q;
      pix_q   <= pix_d;
      sb3_q   <= sb2_q;
    end
  end

endmodule

// File: tb/tb_hevc_luma_interp_pipe.sv
// Bench for hevc_luma_interp_pipe: vector table + random stream scored
// through a queue, plus backpressure, reset and 10-bit corner sequences.
module tb_hevc_luma_interp_pipe;
  import hevc_interp_pkg::*;

  typedef struct {
    logic [63:0] px;
    logic [1:0]  ph;
    logic        m;
    logic [1:0]  sb;
    logic [15:0] exp;
  } vec_t;

  typedef struct {
    logic [15:0] pix;
    logic [1:0]  sb;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_mode, out_valid, out_ready;
  logic [63:0] in_pixels;
  logic [1:0]  in_phase, in_sb, out_sb;
  logic [15:0] out_pixel;

  logic        v10, rdy10, md10, ov10;
  logic [79:0] px10;
  logic [1:0]  ph10, sb10, osb10;
  logic [15:0] op10;

  int   tests = 0, fails = 0, cyc = 0, n_out = 0, last_acc = 0;
  exp_t sbq[$];
  exp_t e;
  logic        held = 1'b0;
  logic [15:0] hpix;
  logic [1:0]  hsb;
  logic        rnd_done;

  int CF [4][8] = '{
    '{ 0, 0,   0, 64,  0,   0, 0,  0},
    '{-1, 4, -10, 58, 17,  -5, 1,  0},
    '{-1, 4, -11, 40, 40, -11, 4, -1},
    '{ 0, 1,  -5, 17, 58, -10, 4, -1}
  };

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  hevc_luma_interp_pipe #(.BIT_DEPTH(8), .SB_W(2), .INT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixels(in_pixels),
    .in_phase(in_phase), .in_mode(in_mode), .in_sb(in_sb),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pixel(out_pixel), .out_sb(out_sb)
  );

  hevc_luma_interp_pipe #(.BIT_DEPTH(10), .SB_W(2), .INT_W(16)) dut10 (
    .clock(clock), .reset(reset),
    .in_valid(v10), .in_ready(rdy10), .in_pixels(px10),
    .in_phase(ph10), .in_mode(md10), .in_sb(sb10),
    .out_valid(ov10), .out_ready(1'b1),
    .out_pixel(op10), .out_sb(osb10)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] px1(input int k, input logic [7:0] v);
    logic [63:0] r = '0;
    r[k*8 +: 8] = v;
    return r;
  endfunction

  function automatic logic [15:0] model(input logic [63:0] px, input logic [1:0] ph, input logic m);
    int s = 0;
    int r;
    for (int k = 0; k < 8; k++) s += CF[ph][k] * int'(px[k*8 +: 8]);
    if (!m) begin
      r = (s + 32) >>> 6;
      if (r < 0) r = 0;
      if (r > 255) r = 255;
    end else begin
      r = s;
      if (r > 32767) r = 32767;
      if (r < -32768) r = -32768;
    end
    return 16'(r);
  endfunction

  // Called at a negedge; returns at the negedge after acceptance, in_valid left high.
  task automatic send(input vec_t v);
    int g = 0;
    in_pixels = v.px; in_phase = v.ph; in_mode = v.m; in_sb = v.sb; in_valid = 1'b1;
    #1;
    while (!in_ready && g < 50) begin @(negedge clock); #1; g++; end
    if (!in_ready) chk("send_timeout", 0, 1);
    else begin
      sbq.push_back('{pix: v.exp, sb: v.sb});
      last_acc = cyc;
    end
    @(negedge clock);
  endtask

  task automatic drain();
    int g = 0;
    while (sbq.size() != 0 && g < 100) begin @(negedge clock); g++; end
    chk("drain", sbq.size(), 0);
  endtask

  task automatic run10(input string nm, input logic m, input logic [15:0] exp);
    int g = 0;
    @(negedge clock);
    px10 = {8{10'd1023}}; ph10 = PH_3Q; md10 = m; sb10 = 2'd1; v10 = 1'b1;
    #1 chk({nm, "_in_ready"}, rdy10, 1);
    @(negedge clock); v10 = 1'b0;
    #1;
    while (!ov10 && g < 20) begin @(negedge clock); #1; g++; end
    chk({nm, "_valid"}, ov10, 1);
    chk(nm, op10, exp);
    chk({nm, "_sb"}, osb10, 1);
  endtask

  // Output monitor / scoreboard consumer; also checks hold-stability under stall.
  always @(negedge clock) begin
    #2;
    if (reset) held = 1'b0;
    else begin
      if (held) begin
        chk("hold_pixel", out_pixel, hpix);
        chk("hold_sb", out_sb, hsb);
      end
      held = out_valid && !out_ready;
      hpix = out_pixel;
      hsb  = out_sb;
      if (out_valid && out_ready) begin
        n_out++;
        if (sbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_output: got pixel %0h, expected no output", out_pixel);
        end else begin
          e = sbq.pop_front();
          chk("out_pixel", out_pixel, e.pix);
          chk("out_sb", out_sb, e.sb);
        end
      end
    end
  end

  initial begin
    vec_t tbl[10];
    vec_t v;
    int   g, base;
    reset = 1'b1; in_valid = 1'b0; in_pixels = '0; in_phase = '0; in_mode = 1'b0;
    in_sb = '0; out_ready = 1'b1;
    v10 = 1'b0; px10 = '0; ph10 = '0; md10 = 1'b0; sb10 = '0; rdy10 = 1'b0;
    rnd_done = 1'b0;

    tbl[0] = '{px1(3, 8'd100), PH_FULL, MODE_FINAL, 2'd2, 16'd100};
    tbl[1] = '{px1(3, 8'd255) | px1(4, 8'd255), PH_H, MODE_FINAL, 2'd1, 16'd255};
    tbl[2] = '{px1(3, 8'd255) | px1(4, 8'd255), PH_H, MODE_INT,   2'd3, 16'd20400};
    tbl[3] = '{px1(2, 8'd255) | px1(5, 8'd255), PH_H, MODE_FINAL, 2'd0, 16'd0};
    tbl[4] = '{px1(2, 8'd255) | px1(5, 8'd255), PH_H, MODE_INT,   2'd1, 16'hEA16};
    tbl[5] = '{{8{8'd128}}, PH_Q, MODE_FINAL, 2'd2, 16'd128};
    for (int i = 0; i < 4; i++) tbl[6+i] = '{{8{8'd128}}, 2'(i), MODE_FINAL, 2'(i), 16'd128};

    repeat (2) @(negedge clock);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_sb", out_sb, 0);
    @(negedge clock); reset = 1'b0;
    @(negedge clock);

    // Latency from acceptance on an idle pipe.
    send(tbl[0]); in_valid = 1'b0;
    g = 0; #1;
    while (!out_valid && g < 10) begin @(negedge clock); #1; g++; end
    chk("latency", cyc - last_acc, 3);
    drain();

    // Whole table back-to-back, including the four phases on consecutive cycles.
    for (int i = 0; i < 10; i++) send(tbl[i]);
    in_valid = 1'b0;
    drain();

    // Random stream with random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          v.px = {$urandom, $urandom};
          v.ph = 2'($urandom_range(0, 3));
          v.m  = 1'($urandom_range(0, 1));
          v.sb = 2'($urandom_range(0, 3));
          v.exp = model(v.px, v.ph, v.m);
          send(v);
          if ($urandom_range(0, 3) == 0) begin in_valid = 1'b0; @(negedge clock); end
        end
        in_valid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clock);
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Backpressure: 4 samples, output stalled for 5 cycles.
    @(negedge clock);
    out_ready = 1'b0;
    base = n_out;
    fork
      begin
        for (int i = 0; i < 4; i++)
          send('{{8{8'(10*(i+1))}}, 2'(i), MODE_FINAL, 2'(3-i), 16'(10*(i+1))});
        in_valid = 1'b0;
      end
      begin
        repeat (3) @(negedge clock);
        #1;
        chk("bp_out_valid", out_valid, 1);
        chk("bp_in_ready", in_ready, 0);
        repeat (2) @(negedge clock);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_count", n_out - base, 4);

    // Reset with samples in flight and one held at the output.
    @(negedge clock);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send('{{8{8'(50+i)}}, PH_H, MODE_FINAL, 2'(i), 16'(50+i)});
    in_valid = 1'b0;
    #3 reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_pixel", out_pixel, 0);
    sbq.delete();
    base = n_out;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (8) @(negedge clock);
    chk("no_stale_output", n_out - base, 0);

    // 10-bit instance, phase 3.
    run10("bd10_final", MODE_FINAL, 16'd1023);
    run10("bd10_int", MODE_INT, 16'd16368);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
